// File: rtl/base_logic_16_bit_pipelined_post_processing.sv
// Three-stage Kogge-Stone post-processing for a 16-bit adder with optional
// approximate low-order carries and a valid/ready stall interface.
module base_logic_16_bit_pipelined_post_processing #(
    parameter int unsigned APPROX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] p,
    input  logic [16:0] g,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [16:0] sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  occupancy
);
    localparam int unsigned W = 16;
    localparam logic [W-1:0] LOW_MASK = W'((17'd1 << APPROX_BITS) - 17'd1);

    // One Kogge-Stone level: combine each bit with the bit 'span' below it.
    function automatic logic [2*W-1:0] ks_level(input logic [W-1:0] gin,
                                                input logic [W-1:0] pin,
                                                input int unsigned  span);
        logic [W-1:0] gout;
        logic [W-1:0] pout;
        gout = gin;
        pout = pin;
        for (int unsigned i = span; i < W; i++) begin
            gout[i] = gin[i] | (pin[i] & gin[i-span]);
            pout[i] = pin[i] & pin[i-span];
        end
        return {gout, pout};
    endfunction

    function automatic logic [W-1:0] ks_gen(input logic [W-1:0] gin,
                                            input logic [W-1:0] pin,
                                            input int unsigned  span);
        logic [W-1:0] gout;
        gout = gin;
        for (int unsigned i = span; i < W; i++) begin
            gout[i] = gin[i] | (pin[i] & gin[i-span]);
        end
        return gout;
    endfunction

    logic         advance;
    logic         accept;
    logic         retire;
    logic         v1, v2, v3;
    logic [W-1:0] s1_p;
    logic [W:0]   s1_g;
    logic [W-1:0] s2_g, s2_p, s2_sp, s2_clo;
    logic         s2_g16;
    logic [W-1:0] l0_g, l0_p, l1_g, l1_p, l2_g, l2_p, l3_g, l3_p, l4_g;
    logic [W:0]   carry;
    logic [W:0]   sum_d;

    assign advance   = ~v3 | out_ready;
    assign in_ready  = advance;
    assign out_valid = v3;
    assign accept    = in_valid & advance;
    assign retire    = v3 & out_ready;

    // Bits below APPROX_BITS-1 are removed from the tree; bit APPROX_BITS-1
    // keeps only its generate so it acts as carry-in for the exact section.
    always_comb begin
        l0_g = s1_g[W-1:0] & ~(LOW_MASK >> 1);
        l0_p = s1_p & ~LOW_MASK;
        {l1_g, l1_p} = ks_level(l0_g, l0_p, 1);
        {l2_g, l2_p} = ks_level(l1_g, l1_p, 2);
    end

    always_comb begin
        {l3_g, l3_p} = ks_level(s2_g, s2_p, 4);
        l4_g  = ks_gen(l3_g, l3_p, 8);
        carry = {(l4_g & ~LOW_MASK) | s2_clo, 1'b0};
        sum_d = {s2_g16, s2_sp} ^ carry;
    end

    // Stage valid bits shift together only when the output slot can move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (advance) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_p   <= '0;
            s1_g   <= '0;
            s2_g   <= '0;
            s2_p   <= '0;
            s2_sp  <= '0;
            s2_clo <= '0;
            s2_g16 <= 1'b0;
            sum    <= '0;
        end else begin
            if (advance && in_valid) begin
                s1_p <= p;
                s1_g <= g;
            end
            if (advance && v1) begin
                s2_g   <= l2_g;
                s2_p   <= l2_p;
                s2_sp  <= s1_p;
                s2_clo <= s1_g[W-1:0] & LOW_MASK;
                s2_g16 <= s1_g[W];
            end
            if (advance && v2) begin
                sum <= sum_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= 2'd0;
        end else begin
            case ({accept, retire})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end
endmodule

// File: tb/tb_base_logic_16_bit_pipelined_post_processing.sv
// Bench for the post-processing stage: three instances (APPROX_BITS 0, 4, 8)
// share stimulus and are scored against a ripple-carry reference model.
module tb_base_logic_16_bit_pipelined_post_processing;
    localparam int unsigned ND    = 3;
    localparam int unsigned DEPTH = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic [15:0]           p;
    logic [16:0]           g;
    logic                  in_valid;
    logic                  out_ready;
    logic [ND-1:0]         ir;
    logic [ND-1:0]         ov;
    logic [ND-1:0][16:0]   sm;
    logic [ND-1:0][1:0]    occ;

    base_logic_16_bit_pipelined_post_processing #(.APPROX_BITS(0)) u_a0 (
        .clk(clk), .rst_n(rst_n), .p(p), .g(g), .in_valid(in_valid), .in_ready(ir[0]),
        .sum(sm[0]), .out_valid(ov[0]), .out_ready(out_ready), .occupancy(occ[0]));
    base_logic_16_bit_pipelined_post_processing #(.APPROX_BITS(4)) u_a4 (
        .clk(clk), .rst_n(rst_n), .p(p), .g(g), .in_valid(in_valid), .in_ready(ir[1]),
        .sum(sm[1]), .out_valid(ov[1]), .out_ready(out_ready), .occupancy(occ[1]));
    base_logic_16_bit_pipelined_post_processing #(.APPROX_BITS(8)) u_a8 (
        .clk(clk), .rst_n(rst_n), .p(p), .g(g), .in_valid(in_valid), .in_ready(ir[2]),
        .sum(sm[2]), .out_valid(ov[2]), .out_ready(out_ready), .occupancy(occ[2]));

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [16:0] exp_mem [ND][DEPTH];
    int unsigned wr_ptr [ND];
    int unsigned rd_ptr [ND];
    logic        hold_pend [ND];
    logic [16:0] held [ND];
    logic [ND-1:0] ir_s, ov_s;
    logic [16:0] sm_s [ND];
    logic [1:0]  occ_s [ND];
    logic        acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int unsigned approx_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 4 : 8;
    endfunction

    // Ripple reference: low carries copy g, upper carries ripple from c[A].
    function automatic logic [16:0] model(input logic [15:0] pv, input logic [16:0] gv,
                                          input int unsigned a);
        logic [16:0] c;
        c = '0;
        for (int k = 1; k <= 16; k++) begin
            if (k <= int'(a)) c[k] = gv[k-1];
            else              c[k] = gv[k-1] | (pv[k-1] & c[k-1]);
        end
        return {gv[16], pv} ^ c;
    endfunction

    // Sample at the falling edge, score handshakes, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            ir_s[d]  = ir[d];
            ov_s[d]  = ov[d];
            sm_s[d]  = sm[d];
            occ_s[d] = occ[d];
            check($sformatf("occupancy%0d", d), 32'(occ[d]), wr_ptr[d] - rd_ptr[d]);
            check($sformatf("in_ready%0d", d), 32'(ir[d]), 32'(!ov[d] || out_ready));
            if (hold_pend[d]) begin
                check($sformatf("held_valid%0d", d), 32'(ov[d]), 32'd1);
                check($sformatf("held_sum%0d", d), 32'(sm[d]), 32'(held[d]));
            end
            if (ov[d] && out_ready) begin
                if (wr_ptr[d] == rd_ptr[d]) begin
                    check($sformatf("spurious_out%0d", d), 32'(ov[d]), 32'd0);
                end else begin
                    check($sformatf("sum%0d", d), 32'(sm[d]), 32'(exp_mem[d][rd_ptr[d] % DEPTH]));
                    rd_ptr[d]++;
                end
            end
            hold_pend[d] = ov[d] && !out_ready;
            held[d]      = sm[d];
            if (in_valid && ir[d]) begin
                exp_mem[d][wr_ptr[d] % DEPTH] = model(p, g, approx_of(d));
                wr_ptr[d]++;
            end
        end
        acc = in_valid && ir[0];
        @(posedge clk);
        #1;
    endtask

    task automatic single(input logic [15:0] pv, input logic [16:0] gv,
                          input int d, input logic [16:0] want);
        in_valid  = 1'b1;
        p         = pv;
        g         = gv;
        out_ready = 1'b1;
        tick();
        check("single_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        p        = 16'($urandom);
        g        = 17'($urandom);
        for (int k = 1; k <= 4; k++) begin
            tick();
            for (int j = 0; j < ND; j++)
                check($sformatf("latency_valid%0d_c%0d", j, k), 32'(ov_s[j]), 32'(k == 3));
            if (k == 3) check($sformatf("directed_sum%0d", d), 32'(sm_s[d]), 32'(want));
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("%s_out_valid%0d", tag, d), 32'(ov[d]), 32'd0);
            check($sformatf("%s_occupancy%0d", tag, d), 32'(occ[d]), 32'd0);
            check($sformatf("%s_sum%0d", tag, d), 32'(sm[d]), 32'd0);
            check($sformatf("%s_in_ready%0d", tag, d), 32'(ir[d]), 32'd1);
        end
    endtask

    task automatic stream8();
        int sent;
        int peak;
        sent     = 0;
        peak     = 0;
        acc      = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (acc) sent++;
            if (!(in_valid && !acc)) begin
                p = 16'($urandom);
                g = 17'($urandom);
            end
            in_valid  = (sent < 8);
            out_ready = !(c >= 5 && c <= 7);
            tick();
            for (int d = 0; d < ND; d++) begin
                if (c >= 5 && c <= 7) check($sformatf("stall_in_ready%0d", d), 32'(ir_s[d]), 32'd0);
                if (int'(occ_s[d]) > peak) peak = int'(occ_s[d]);
            end
        end
        if (acc) sent++;
        check("stream_sent", 32'(sent), 32'd8);
        check("stream_occ_peak", 32'(peak), 32'd3);
        for (int d = 0; d < ND; d++)
            check($sformatf("stream_drained%0d", d), wr_ptr[d] - rd_ptr[d], 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        p         = 16'hA5A5;
        g         = 17'h15A5A;
        out_ready = 1'b1;
        acc       = 1'b0;
        for (int d = 0; d < ND; d++) begin
            wr_ptr[d]    = 0;
            rd_ptr[d]    = 0;
            hold_pend[d] = 1'b0;
            held[d]      = '0;
        end
        #22;
        check_reset_state("reset");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        single(16'h00FF, 17'h00000, 0, 17'h000FF);
        single(16'hFFFE, 17'h00001, 0, 17'h10000);
        single(16'hFFFE, 17'h10001, 0, 17'h00000);
        single(16'hFFFE, 17'h00001, 1, 17'h0FFFC);
        single(16'hFFFE, 17'h00001, 2, 17'h0FFFC);

        stream8();

        // Three transactions in flight, then an asynchronous reset mid-cycle.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p = 16'($urandom);
            g = 17'($urandom);
            tick();
        end
        for (int d = 0; d < ND; d++)
            check($sformatf("inflight_occ%0d", d), 32'(occ[d]), 32'd3);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("midreset");
        for (int d = 0; d < ND; d++) begin
            rd_ptr[d]    = wr_ptr[d];
            hold_pend[d] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            tick();
            for (int d = 0; d < ND; d++)
                check($sformatf("post_reset_idle%0d", d), 32'(ov_s[d]), 32'd0);
        end

        // Random traffic with random valid/ready; held data while stalled.
        acc      = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 26000; c++) begin
            if (!(in_valid && !acc)) begin
                p        = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                g        = 17'($urandom);
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        for (int d = 0; d < ND; d++)
            check($sformatf("random_drained%0d", d), wr_ptr[d] - rd_ptr[d], 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
